tkip_sbox_arbiter: RTL and testbench

TKIP_SBOX_ARBITER -- requirements
Module: tkip_sbox_arbiter

---
 rtl/tkip_sbox_arbiter_if.sv | 31 +++
 rtl/tkip_sbox_arbiter.sv | 68 ++++++
 tb/tb_tkip_sbox_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/tkip_sbox_arbiter_if.sv
// tkip_sbox_arbiter_if: requester, sBox table and response signals shared by the two TKIP key mixers and the arbiter.
interface tkip_sbox_arbiter_if;
  logic        arbMode;
  logic        sBoxFlush;
  logic        p1Req;
  logic        p2Req;
  logic [7:0]  p1AddrLo;
  logic [7:0]  p1AddrHi;
  logic [7:0]  p2AddrLo;
  logic [7:0]  p2AddrHi;
  logic        p1Gnt;
  logic        p2Gnt;
  logic [7:0]  sBoxAddressA;
  logic [7:0]  sBoxAddressB;
  logic [15:0] sBoxDataA;
  logic [15:0] sBoxDataB;
  logic        rspValidP1;
  logic        rspValidP2;
  logic [15:0] rspData;
  logic        busy;
  modport master (
    output arbMode, sBoxFlush, p1Req, p2Req, p1AddrLo, p1AddrHi, p2AddrLo, p2AddrHi,
    output sBoxDataA, sBoxDataB,
    input  p1Gnt, p2Gnt, sBoxAddressA, sBoxAddressB, rspValidP1, rspValidP2, rspData, busy
  );
  modport slave (
    input  arbMode, sBoxFlush, p1Req, p2Req, p1AddrLo, p1AddrHi, p2AddrLo, p2AddrHi,
    input  sBoxDataA, sBoxDataB,
    output p1Gnt, p2Gnt, sBoxAddressA, sBoxAddressB, rspValidP1, rspValidP2, rspData, busy
  );
endinterface

// File: rtl/tkip_sbox_arbiter.sv
// tkip_sbox_arbiter: shares one sBox table pair between two key mixers with burst-limited round-robin or P2-priority arbitration.
module tkip_sbox_arbiter #(
  parameter int GRANT_MAX = 4
) (
  input logic bbClk,
  input logic hardRstBbClk,
  tkip_sbox_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN_P1, OWN_P2} state_t;
  localparam logic [3:0] GMAX = 4'(GRANT_MAX);
  state_t state;
  logic [3:0] grant_cnt;
  logic last_p2, s1_v, s1_p2, s2_v, s2_p2;
  logic [7:0] addr_a, addr_b;
  logic blk, own_req, oth_req, own_gnt, g1_raw, g2_raw, g1, g2;
  state_t next_own;
  always_comb begin
    blk = bus.sBoxFlush | hardRstBbClk;
    own_req = state == OWN_P1 ? bus.p1Req : bus.p2Req;
    oth_req = state == OWN_P1 ? bus.p2Req : bus.p1Req;
    own_gnt = own_req & ((grant_cnt < GMAX) | ~oth_req);
    g2_raw = bus.arbMode ? bus.p2Req :
             state == IDLE ? bus.p2Req & (~bus.p1Req | ~last_p2) :
             state == OWN_P2 ? own_gnt : bus.p2Req & ~own_gnt;
    // P1 takes whatever P2 does not, except when P1 owns the round-robin burst
    g1_raw = (state == OWN_P1 && !bus.arbMode) ? own_gnt : bus.p1Req & ~g2_raw;
    g1 = g1_raw & ~blk;
    g2 = g2_raw & ~blk;
    next_own = g2 ? OWN_P2 : OWN_P1;
  end
  always_ff @(posedge bbClk) begin
    if (hardRstBbClk) begin
      state <= IDLE;
      grant_cnt <= 4'd0;
      last_p2 <= 1'b1;
      s1_v <= 1'b0;
      s1_p2 <= 1'b0;
      s2_v <= 1'b0;
      s2_p2 <= 1'b0;
      addr_a <= 8'h00;
      addr_b <= 8'h00;
    end else begin
      s1_v <= g1 | g2;
      s1_p2 <= g2;
      s2_v <= s1_v & ~bus.sBoxFlush;
      s2_p2 <= s1_p2;
      if (g1 | g2) begin
        addr_a <= g2 ? bus.p2AddrLo : bus.p1AddrLo;
        addr_b <= g2 ? bus.p2AddrHi : bus.p1AddrHi;
        last_p2 <= g2;
        state <= next_own;
        grant_cnt <= state != next_own ? 4'd1 : grant_cnt == GMAX ? GMAX : grant_cnt + 4'd1;
      end else begin
        state <= IDLE;
        grant_cnt <= 4'd0;
      end
    end
  end
  // the flush/reset cycle also hides the lookup already sitting in stage 2
  assign bus.p1Gnt = g1;
  assign bus.p2Gnt = g2;
  assign bus.sBoxAddressA = addr_a;
  assign bus.sBoxAddressB = addr_b;
  assign bus.rspValidP1 = s2_v & ~s2_p2 & ~blk;
  assign bus.rspValidP2 = s2_v & s2_p2 & ~blk;
  assign bus.rspData = bus.sBoxDataA ^ bus.sBoxDataB;
  assign bus.busy = s1_v | s2_v | (state != IDLE);
endmodule

// File: tb/tb_tkip_sbox_arbiter.sv
// tb_tkip_sbox_arbiter: directed vector table plus randomized traffic checked against a behavioural arbiter model.
module tb_tkip_sbox_arbiter;
  localparam int GM = 4;
  logic bbClk = 1'b0;
  logic hardRstBbClk;
  tkip_sbox_arbiter_if bus ();
  tkip_sbox_arbiter #(.GRANT_MAX(GM)) dut (.bbClk(bbClk), .hardRstBbClk(hardRstBbClk), .bus(bus));
  always #5 bbClk = ~bbClk;

  logic [15:0] tab_a [256];
  logic [15:0] tab_b [256];
  always @(posedge bbClk) begin
    bus.sBoxDataA <= tab_a[bus.sBoxAddressA];
    bus.sBoxDataB <= tab_b[bus.sBoxAddressB];
  end

  typedef struct {int due; int id; logic [15:0] data;} lk_t;
  lk_t q[$];
  int m_own, m_cnt, m_last, cyc;
  logic [7:0] m_addr_a, m_addr_b;
  int n_chk = 0, n_bad = 0, n_vec = 0;
  logic mode = 1'b0;

  typedef struct {logic rst, md, flush, p1, p2, g1, g2, r1, r2, busy;} vec_t;
  vec_t tv [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_cnt = 0; m_last = 2; q.delete(); m_addr_a = 8'h00; m_addr_b = 8'h00;
  endtask

  function automatic int ref_grant();
    bit p1, p2, own_req, oth_req;
    p1 = bus.p1Req; p2 = bus.p2Req;
    if (hardRstBbClk || bus.sBoxFlush) return 0;
    if (bus.arbMode) return p2 ? 2 : p1 ? 1 : 0;
    if (m_own == 0) return (p1 && p2) ? 3 - m_last : p2 ? 2 : p1 ? 1 : 0;
    own_req = (m_own == 1) ? p1 : p2;
    oth_req = (m_own == 1) ? p2 : p1;
    if (own_req && (m_cnt < GM || !oth_req)) return m_own;
    return oth_req ? 3 - m_own : 0;
  endfunction

  task automatic drive(input logic r, input logic md, input logic f, input logic p1, input logic p2,
                       input logic [7:0] lo1, input logic [7:0] hi1);
    hardRstBbClk = r; bus.arbMode = md; bus.sBoxFlush = f; bus.p1Req = p1; bus.p2Req = p2;
    bus.p1AddrLo = lo1; bus.p1AddrHi = hi1;
    bus.p2AddrLo = 8'($urandom); bus.p2AddrHi = 8'($urandom);
    #1;
  endtask

  task automatic step();
    int g;
    bit ev;
    g = ref_grant();
    ev = !hardRstBbClk && !bus.sBoxFlush && q.size() > 0 && q[0].due == cyc;
    chk("p1Gnt", 32'(bus.p1Gnt), 32'(g == 1));
    chk("p2Gnt", 32'(bus.p2Gnt), 32'(g == 2));
    chk("rspValidP1", 32'(bus.rspValidP1), 32'(ev && q[0].id == 1));
    chk("rspValidP2", 32'(bus.rspValidP2), 32'(ev && q[0].id == 2));
    if (ev) chk("rspData", 32'(bus.rspData), 32'(q[0].data));
    chk("sBoxAddressA", 32'(bus.sBoxAddressA), 32'(m_addr_a));
    chk("sBoxAddressB", 32'(bus.sBoxAddressB), 32'(m_addr_b));
    chk("busy", 32'(bus.busy), 32'(q.size() > 0 || m_own != 0));
    if (hardRstBbClk) model_reset();
    else begin
      if (bus.sBoxFlush) q.delete();
      else if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
      if (g != 0) begin
        logic [7:0] lo, hi;
        lo = (g == 1) ? bus.p1AddrLo : bus.p2AddrLo;
        hi = (g == 1) ? bus.p1AddrHi : bus.p2AddrHi;
        q.push_back('{cyc + 2, g, tab_a[lo] ^ tab_b[hi]});
        m_addr_a = lo; m_addr_b = hi;
        m_cnt = (g == m_own) ? ((m_cnt < GM) ? m_cnt + 1 : GM) : 1;
        m_own = g; m_last = g;
      end else begin
        m_own = 0; m_cnt = 0;
      end
    end
    n_vec++;
    @(posedge bbClk); #1;
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tab_a[i] = 16'($urandom);
      tab_b[i] = 16'($urandom);
    end
    tab_a[0] = 16'hC6A5;
    tab_b[1] = 16'h7C84;
    tv[0]  = '{0,0,0,1,1, 0,1,0,0,0};
    tv[1]  = '{0,0,0,1,1, 0,1,0,0,1};
    tv[2]  = '{0,0,0,1,1, 0,1,0,1,1};
    tv[3]  = '{0,0,0,1,1, 0,1,0,1,1};
    tv[4]  = '{0,0,0,1,1, 1,0,0,1,1};
    tv[5]  = '{0,0,0,1,1, 1,0,0,1,1};
    tv[6]  = '{0,0,0,0,1, 0,1,1,0,1};
    tv[7]  = '{0,0,0,0,1, 0,1,1,0,1};
    tv[8]  = '{0,1,0,1,1, 0,1,0,1,1};
    tv[9]  = '{0,1,0,1,1, 0,1,0,1,1};
    tv[10] = '{0,1,0,1,0, 1,0,0,1,1};
    tv[11] = '{0,0,0,1,0, 1,0,0,1,1};
    tv[12] = '{0,0,0,1,0, 1,0,1,0,1};
    tv[13] = '{0,0,1,1,0, 0,0,0,0,1};
    tv[14] = '{0,0,0,0,0, 0,0,0,0,0};
    tv[15] = '{0,0,0,1,0, 1,0,0,0,0};
    tv[16] = '{0,0,0,1,0, 1,0,0,0,1};
    tv[17] = '{0,0,0,1,0, 1,0,1,0,1};
    tv[18] = '{1,0,0,1,0, 0,0,0,0,1};
    tv[19] = '{0,0,0,0,0, 0,0,0,0,0};
    tv[20] = '{0,0,0,1,1, 1,0,0,0,0};
    tv[21] = '{0,0,0,0,0, 0,0,0,0,1};
    tv[22] = '{0,0,0,0,0, 0,0,1,0,1};
    tv[23] = '{0,0,0,0,0, 0,0,0,0,0};
    cyc = 0;
    drive(1, 0, 0, 0, 0, 8'h00, 8'h00);
    @(posedge bbClk); #1;
    model_reset();
    drive(1, 0, 0, 1, 1, 8'h00, 8'h00);
    step();
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_addr", {16'h0, bus.sBoxAddressA, bus.sBoxAddressB}, 32'h0);
    step();
    drive(0, 0, 0, 1, 0, 8'h00, 8'h01);
    chk("single_p1_gnt", 32'(bus.p1Gnt), 32'h1);
    step();
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    chk("single_p1_addr", {16'h0, bus.sBoxAddressA, bus.sBoxAddressB}, 32'h0001);
    step();
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    chk("single_p1_rsp", {15'h0, bus.rspValidP1, bus.rspData}, 32'h1BA21);
    step();
    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].md, tv[i].flush, tv[i].p1, tv[i].p2, 8'($urandom), 8'($urandom));
      chk($sformatf("tv%0d_gnt", i), {bus.p1Gnt, bus.p2Gnt}, {tv[i].g1, tv[i].g2});
      chk($sformatf("tv%0d_rsp", i), {bus.rspValidP1, bus.rspValidP2}, {tv[i].r1, tv[i].r2});
      chk($sformatf("tv%0d_busy", i), 32'(bus.busy), 32'(tv[i].busy));
      step();
    end
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      drive($urandom_range(0, 199) == 0, mode, $urandom_range(0, 59) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom));
      if (bus.p1Gnt && bus.p2Gnt) chk("both_gnt", 32'h1, 32'h0);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
